// File: rtl/tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, byte width, default watchdog length.
package tx_arbiter_pkg;

  localparam int DATA_W      = 8;
  localparam int DEF_TMO_CYC = 65535;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational requester pick: first set req at or after ptr, wrapping; zero latency.
// With TX_ARB_FIXED_PRIO_EN defined it is a plain lowest-index priority encoder and ptr is ignored.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx
);

`ifdef TX_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W:0] slot;
  logic           found;

  // Walk the ring starting at ptr; slot is kept one bit wider so the wrap test cannot overflow.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    slot    = '0;
    for (int i = 0; i < NREQ; i++) begin
      slot = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (slot >= (PTR_W + 1)'(NREQ)) slot = slot - (PTR_W + 1)'(NREQ);
      if (!found && req[slot[PTR_W-1:0]]) begin
        found                 = 1'b1;
        win[slot[PTR_W-1:0]]  = 1'b1;
        win_idx               = slot[PTR_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter among NREQ byte sources; wr/ack one cycle after req is sampled in IDLE,
// then no new grant until tx_rdy or the watchdog. Macro TX_ARB_FIXED_PRIO_EN selects fixed priority.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TMO_CYC = DEF_TMO_CYC,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] din,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      dout,
  output logic                   wr,
  input  logic                   tx_rdy,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   tmo
);

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NREQ - 1);

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner_idx;
  logic [CNT_W-1:0]  counter;
  logic [NREQ-1:0]   pick_win;
  logic [PTR_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_byte;
  logic [PTR_W-1:0]  next_ptr;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) pick_byte = din[DATA_W*i +: DATA_W];
    end
  end

`ifdef TX_ARB_FIXED_PRIO_EN
  logic unused_owner;
  assign unused_owner = ^owner_idx;
  assign next_ptr     = '0;
`else
  assign next_ptr = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner_idx <= '0;
      counter   <= '0;
      dout      <= '0;
      wr        <= 1'b0;
      ack       <= '0;
      grant     <= '0;
      tmo       <= 1'b0;
    end else begin
      wr  <= 1'b0;
      ack <= '0;
      tmo <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            dout      <= pick_byte;
            grant     <= pick_win;
            ack       <= pick_win;
            wr        <= 1'b1;
            owner_idx <= pick_idx;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          counter <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          counter <= counter + CNT_W'(1);
          // tx_rdy takes precedence over a watchdog expiry landing on the same edge.
          if (tx_rdy) begin
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end else if (counter == TMO_LAST) begin
            tmo   <= 1'b1;
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter with NREQ=2, TMO_CYC=16: vector table, directed corner sequences, random transactions.
module tb_tx_arbiter;

  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] din;
  logic        tx_rdy;
  logic [1:0]  ack;
  logic [7:0]  dout;
  logic        wr;
  logic [1:0]  grant;
  logic        busy;
  logic        tmo;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;

  tx_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .dout   (dout),
    .wr     (wr),
    .tx_rdy (tx_rdy),
    .grant  (grant),
    .busy   (busy),
    .tmo    (tmo)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] din;
    logic        tx;
    int          rep;
    logic        wr;
    logic [1:0]  ack;
    logic [7:0]  dout;
    logic [1:0]  grant;
    logic        busy;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [14:0] obs();
    return {wr, ack, dout, grant, busy, tmo};
  endfunction

  // Reference arbitration: first requester at or after the pointer, modulo NREQ.
  function automatic int m_pick(input logic [1:0] r, input int p);
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
`endif
    return 0;
  endfunction

  task automatic m_advance(input int w);
`ifdef TX_ARB_FIXED_PRIO_EN
    m_ptr = 0;
`else
    m_ptr = (w + 1) % NREQ;
`endif
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] d, input int w);
    return (w == 0) ? d[7:0] : d[15:8];
  endfunction

  task automatic wait_wr(input int budget);
    int cyc;
    cyc = 0;
    while (wr !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (wr !== 1'b1) chk("wr_wait_expired", 32'(cyc), 32'(budget + 1));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req = 2'b11; tx_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("reset_state", 32'(obs()), 32'd0);
    end
    rst = 1'b0; req = 2'b00;
    m_ptr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish within 1 ms");
    $fatal(1);
  end

  initial begin
    int w;
    int c;
    int cnt;
    logic [1:0]  r;
    logic [1:0]  exp_g;
    logic [15:0] d;
    logic [7:0]  exp_b;
    logic        exp_t;
    vec_t        v;

    rst = 1'b1; req = 2'b11; din = 16'hFFFF; tx_rdy = 1'b0;
    do_reset(3);

    //            req    din       tx  rep  wr   ack    dout   grant  busy tmo
    vecs.push_back('{2'b01, 16'h0041, 1'b0, 1,  1'b1, 2'b01, 8'h41, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 1,  1'b0, 2'b00, 8'h41, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 8,  1'b0, 2'b00, 8'h41, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b1, 1,  1'b0, 2'b00, 8'h41, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b1, 2,  1'b0, 2'b00, 8'h41, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 16'hAA00, 1'b0, 1,  1'b1, 2'b10, 8'hAA, 2'b10, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b1, 1,  1'b0, 2'b00, 8'hAA, 2'b10, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 16'h1234, 1'b0, 15, 1'b0, 2'b00, 8'hAA, 2'b10, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 1,  1'b0, 2'b00, 8'hAA, 2'b10, 1'b0, 1'b1});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 1,  1'b0, 2'b00, 8'hAA, 2'b10, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 16'h0077, 1'b0, 1,  1'b1, 2'b01, 8'h77, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 1,  1'b0, 2'b00, 8'h77, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b0, 15, 1'b0, 2'b00, 8'h77, 2'b01, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 16'h0000, 1'b1, 1,  1'b0, 2'b00, 8'h77, 2'b01, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      for (int k = 0; k < v.rep; k++) begin
        req = v.req; din = v.din; tx_rdy = v.tx;
        tick();
        chk($sformatf("vec%0d", i), 32'(obs()),
            32'({v.wr, v.ack, v.dout, v.grant, v.busy, v.tmo}));
      end
    end
    req = 2'b00; tx_rdy = 1'b0;

    // Rotation under continuous demand, tx_rdy a few cycles after each strobe.
    do_reset(1);
    req = 2'b11; din = 16'hAA55;
    for (int t = 0; t < 4; t++) begin
      wait_wr(4);
      w = m_pick(2'b11, m_ptr);
      exp_g = 2'(1 << w);
      chk($sformatf("rot%0d", t), 32'({ack, dout, grant}), 32'({exp_g, byte_of(din, w), exp_g}));
      repeat (4) tick();
      tx_rdy = 1'b1;
      if (t == 3) req = 2'b00;
      tick();
      tx_rdy = 1'b0;
      chk($sformatf("rot%0d_busy", t), 32'(busy), 32'd0);
      m_advance(w);
    end

    // Watchdog expiry with no tx_rdy, then the next grant.
    do_reset(1);
    req = 2'b11; din = 16'h3C5A;
    wait_wr(4);
    w = m_pick(2'b11, m_ptr);
    chk("tmo_first_grant", 32'(grant), 32'(1 << w));
    tick();
    cnt = 0;
    while (tmo !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_busy", 32'(busy), 32'd0);
    m_advance(w);
    wait_wr(4);
    w = m_pick(2'b11, m_ptr);
    chk("tmo_next_grant", 32'(grant), 32'(1 << w));

    // Finish this frame, win the next one, then reset during its WAIT.
    tick();
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    m_advance(w);
    wait_wr(4);
    w = m_pick(2'b11, m_ptr);
    chk("rst_pre_grant", 32'(grant), 32'(1 << w));
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_frame", 32'(obs()), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    wait_wr(4);
    w = m_pick(2'b11, m_ptr);
    chk("rst_next_grant", 32'(grant), 32'(1 << w));
    tick();
    tx_rdy = 1'b1; req = 2'b00;
    tick();
    tx_rdy = 1'b0;

    // Random transactions with noise on req/din/tx_rdy while the frame is in flight.
    do_reset(1);
    for (int n = 0; n < 60; n++) begin
      r = 2'($urandom_range(1, 3));
      d = 16'($urandom);
      req = r; din = d; tx_rdy = 1'b0;
      w = m_pick(r, m_ptr);
      exp_b = byte_of(d, w);
      exp_g = 2'(1 << w);
      tick();
      chk("rnd_strobe", 32'({wr, ack, dout, grant, busy}), 32'({1'b1, exp_g, exp_b, exp_g, 1'b1}));
      c = $urandom_range(1, 20);
      exp_t = (c > TMO);
      req = 2'($urandom); din = 16'($urandom); tx_rdy = 1'($urandom);
      tick();
      for (int cyc = 1; cyc <= TMO; cyc++) begin
        chk("rnd_hold", 32'({wr, grant, dout, busy}), 32'({1'b0, exp_g, exp_b, 1'b1}));
        if (cyc == c || cyc == TMO) begin
          tx_rdy = (cyc == c);
          req = 2'b00;
          tick();
          break;
        end
        tx_rdy = 1'b0; req = 2'($urandom); din = 16'($urandom);
        tick();
      end
      chk("rnd_end", 32'({busy, tmo}), 32'({1'b0, exp_t}));
      tx_rdy = 1'b0;
      m_advance(w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
